// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell over WIDTH cycles.
// Define SUB_OVERFLOW_EN to add the registered two's-complement overflow output ovf.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb, res;
    logic             br, d, br_next;
    logic [CW-1:0]    cnt;

    always_comb begin
        d       = sa[0] ^ sb[0] ^ br;
        br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa    <= a;
                    sb    <= b;
                    br    <= bin;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {d, res[WIDTH-1:1]};
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= {d, res[WIDTH-1:1]};
                        bout  <= br_next;
`ifdef SUB_OVERFLOW_EN
                        // On the last bit sa[0]/sb[0] hold the operand sign bits.
                        ovf   <= (sa[0] != sb[0]) && (d != sa[0]);
`endif
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: randomized scoreboard bench against an arithmetic reference model.
module tb_serial_ripple_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input int av, input int bv, input int bi);
        exp_t e;
        int   r, sa, sb;
        r  = av - bv - bi;
        e.diff = W'(r & ((1 << W) - 1));
        e.bout = r < 0;
        sa = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        e.ovf = (sa - sb - bi) < -(1 << (W - 1)) || (sa - sb - bi) > (1 << (W - 1)) - 1;
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", int'(diff), int'(e.diff));
                chk("bout", int'(bout), int'(e.bout));
                chk("latency", cyc - e.acc, W);
`ifdef SUB_OVERFLOW_EN
                chk("ovf", int'(ovf), int'(e.ovf));
`endif
            end
        end
    end

    // hold=1 keeps start asserted with fresh operands throughout the busy window.
    task automatic issue(input int av, input int bv, input int bi, input bit hold);
        exp_t e;
        int   nb;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        start = 1'b1;
        a = W'(av);
        b = W'(bv);
        bin = bi[0];
        e = model(av, bv, bi);
        e.acc = cyc + 1;
        q.push_back(e);
        nb = 0;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            nb += int'(busy);
            start = hold && (i < W);
            a = W'($urandom);
            b = W'($urandom);
            bin = 1'($urandom);
        end
        chk("busy_cycles", nb, W + 1);
    endtask

    initial begin
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        rst_n = 1'b1;
        issue(9, 3, 0, 0);
        issue(3, 9, 0, 0);
        issue(0, 0, 1, 0);
        issue(5, 5, 1, 0);
        issue(7, 15, 0, 0);
        issue(3, 1, 0, 1);
        issue(0, 1, 0, 1);
        issue(15, 15, 0, 0);
        // Abort an operation two cycles into RUN with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        a = 4'd12;
        b = 4'd2;
        bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_diff", int'(diff), 0);
        chk("arst_bout", int'(bout), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        chk("arst_no_done_pending", q.size(), 0);
        issue(12, 2, 0, 0);
        for (int i = 0; i < 30; i++)
            issue(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 1)), 1'($urandom));
        repeat (W + 2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
